// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, state codes and constants for the mul/div sequencer
package muldiv_pkg;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one combinational restoring-division step on {rem,quot}
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);
  logic [W:0]   rem_sh;
  logic [W-1:0] diff;

  // The shifted remainder needs one extra bit; after subtraction it always fits in W.
  always_comb begin
    rem_sh = {rem_i, quot_i[W-1]};
    diff   = rem_sh[W-1:0] - divisor_i;
    if (rem_sh >= {1'b0, divisor_i}) begin
      rem_o  = diff;
      quot_o = {quot_i[W-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh[W-1:0];
      quot_o = {quot_i[W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - execute-stage sequencer for MULT/MULTU/DIV/DIVU producing HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DIV_ITERS = muldiv_pkg::DIV_ITERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startE,
  input  logic [1:0]        opE,
  input  logic [DATA_W-1:0] srcaE,
  input  logic [DATA_W-1:0] srcbE,
  input  logic              flushE,
  input  logic              stall_ext,
  output logic              stall_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CNT_W = $clog2(DIV_ITERS);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [DATA_W-1:0]   step_rem, step_quot;
  logic [2*DATA_W-1:0] mul_a, mul_b, prod;
  logic                signed_div_e, a_neg, b_neg;

  muldiv_div_step #(.W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  // Sign-extending to 2W bits makes the low 2W bits of one unsigned multiply serve both ops.
  always_comb begin
    if (op_q == MD_MULT) begin
      mul_a = {{DATA_W{a_q[DATA_W-1]}}, a_q};
      mul_b = {{DATA_W{b_q[DATA_W-1]}}, b_q};
    end else begin
      mul_a = {{DATA_W{1'b0}}, a_q};
      mul_b = {{DATA_W{1'b0}}, b_q};
    end
    prod = mul_a * mul_b;
  end

  assign signed_div_e = (opE == MD_DIV);
  assign a_neg        = (op_q == MD_DIV) && a_q[DATA_W-1];
  assign b_neg        = (op_q == MD_DIV) && b_q[DATA_W-1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (startE && !flushE) begin
          op_d = opE;
          a_d  = srcaE;
          b_d  = srcbE;
          if (opE[1]) begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(DIV_ITERS - 1);
            rem_d   = '0;
            quot_d  = (signed_div_e && srcaE[DATA_W-1]) ? -srcaE : srcaE;
            dvs_d   = (signed_div_e && srcbE[DATA_W-1]) ? -srcbE : srcbE;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        hi_d    = prod[2*DATA_W-1:DATA_W];
        lo_d    = prod[DATA_W-1:0];
        state_d = ST_DONE;
      end
      ST_DIV: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = DATA_W'(DIV0_QUOT);
          end else begin
            hi_d = a_neg ? -step_rem : step_rem;
            lo_d = (a_neg ^ b_neg) ? -step_quot : step_quot;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (!stall_ext) state_d = ST_IDLE;
      end
    endcase
    if (flushE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall_o = !flushE && ((state_q == ST_IDLE && startE) ||
                               state_q == ST_MUL || state_q == ST_DIV);
  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = (state_q == ST_DONE);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
endmodule
